// File: rtl/elevator_if.sv
// Car-side signal bundle: request buttons in, lamps, floor and motion status out.
interface elevator_if #(
  parameter int FLOORS = 3
);
  logic [FLOORS-1:0] button;
  logic [FLOORS-1:0] led;
  logic [FLOORS-1:0] floor;
  logic              door;
  logic              moving;
  logic              dir_up;

  modport master (input button, output led, floor, door, moving, dir_up);
  modport slave  (output button, input led, floor, door, moving, dir_up);
endinterface

// File: rtl/elevator_controller.sv
// N-floor elevator controller: latches requests and serves them in SCAN order,
// with all timing derived from an internal tick prescaler.
//   state     | meaning
//   IDLE      | parked, door closed, waiting for a request
//   MOVING    | travelling one floor per TRAVEL_TICKS ticks
//   DOOR_OPEN | door open for DOOR_TICKS ticks after the last button at this floor
module elevator_controller #(
  parameter int FLOORS       = 3,
  parameter int TICK_DIV     = 50_000_000,
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  elevator_if.master bus
);

  localparam int IW = (FLOORS > 2) ? $clog2(FLOORS) : 1;
  localparam int PW = $clog2((TICK_DIV > 2) ? TICK_DIV : 2);
  localparam int TW = $clog2((TRAVEL_TICKS > 2) ? TRAVEL_TICKS : 2);
  localparam int DW = $clog2((DOOR_TICKS > 2) ? DOOR_TICKS : 2);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_TICKS - 1);
  localparam logic [IW-1:0] TOP_IDX     = IW'(FLOORS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     presc;
  logic [TW-1:0]     travel_cnt;
  logic [DW-1:0]     door_cnt;
  logic [IW-1:0]     floor_idx;
  logic [FLOORS-1:0] led;
  logic              door;
  logic              moving;
  logic              dir_up;

  logic              tick;
  logic [FLOORS-1:0] cur_bit;
  logic [FLOORS-1:0] led_set;
  logic              btn_here;
  logic              at_top;
  logic              at_bot;
  logic              pref_up;
  logic              req_fwd;
  logic              req_back;
  logic              can_step;
  logic [IW-1:0]     next_idx;
  logic [FLOORS-1:0] next_bit;
  logic              arrive_req;
  logic              still_ahead;

  function automatic logic beyond(input logic [FLOORS-1:0] req,
                                  input logic [IW-1:0] pos,
                                  input logic up);
    beyond = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if ((up && (i > int'(pos))) || (!up && (i < int'(pos))))
        beyond = beyond | req[i];
    end
  endfunction

  always_comb begin
    tick     = (presc == PRESC_LAST);
    cur_bit  = FLOORS'(1) << floor_idx;
    // The current floor is only latched while travelling; when parked or open
    // a press there opens (or holds) the door instead.
    led_set  = led | (bus.button & ~((state != MOVING) ? cur_bit : '0));
    btn_here = |(bus.button & cur_bit);
    at_top   = (floor_idx == TOP_IDX);
    at_bot   = (floor_idx == '0);
    pref_up  = at_top ? 1'b0 : (at_bot ? 1'b1 : dir_up);
    req_fwd  = beyond(led, floor_idx, pref_up);
    req_back = beyond(led, floor_idx, ~pref_up);
    can_step = dir_up ? !at_top : !at_bot;
    next_idx = dir_up ? floor_idx + IW'(1) : floor_idx - IW'(1);
    next_bit = FLOORS'(1) << next_idx;
    // Arrival uses this cycle's presses too, so a request never gets stranded
    // at the floor the car parks on.
    arrive_req  = |(led_set & next_bit);
    still_ahead = beyond(led_set, next_idx, dir_up);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      presc      <= '0;
      travel_cnt <= '0;
      door_cnt   <= '0;
      floor_idx  <= '0;
      led        <= '0;
      door       <= 1'b0;
      moving     <= 1'b0;
      dir_up     <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      led   <= led_set;
      case (state)
        IDLE: begin
          if (btn_here) begin
            state    <= DOOR_OPEN;
            door     <= 1'b1;
            door_cnt <= '0;
          end else if (req_fwd || req_back) begin
            state      <= MOVING;
            moving     <= 1'b1;
            dir_up     <= req_fwd ? pref_up : ~pref_up;
            travel_cnt <= '0;
          end
        end
        MOVING: begin
          if (tick) begin
            if (travel_cnt != TRAVEL_LAST) begin
              travel_cnt <= travel_cnt + TW'(1);
            end else begin
              travel_cnt <= '0;
              if (!can_step) begin
                state  <= IDLE;
                moving <= 1'b0;
              end else begin
                floor_idx <= next_idx;
                if (arrive_req) begin
                  led      <= led_set & ~next_bit;
                  state    <= DOOR_OPEN;
                  moving   <= 1'b0;
                  door     <= 1'b1;
                  door_cnt <= '0;
                end else if (!still_ahead) begin
                  state  <= IDLE;
                  moving <= 1'b0;
                end
              end
            end
          end
        end
        DOOR_OPEN: begin
          if (btn_here) begin
            door_cnt <= '0;
          end else if (tick) begin
            if (door_cnt == DOOR_LAST) begin
              door_cnt <= '0;
              door     <= 1'b0;
              state    <= IDLE;
            end else begin
              door_cnt <= door_cnt + DW'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          door   <= 1'b0;
          moving <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led    = led;
  assign bus.floor  = cur_bit;
  assign bus.door   = door;
  assign bus.moving = moving;
  assign bus.dir_up = dir_up;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench: directed scenarios plus random buttons against a floor-level reference model.
module tb_elevator_controller;
  localparam int N      = 4;
  localparam int TRAVEL = 2;
  localparam int DOORT  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;
  elevator_if #(.FLOORS(N)) bus1 ();
  elevator_if #(.FLOORS(N)) bus2 ();

  elevator_controller #(.FLOORS(N), .TICK_DIV(1), .TRAVEL_TICKS(TRAVEL), .DOOR_TICKS(DOORT))
    dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  elevator_controller #(.FLOORS(N), .TICK_DIV(4), .TRAVEL_TICKS(TRAVEL), .DOOR_TICKS(DOORT))
    dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] sb_q[$];

  // Reference model: floor number, direction, what the car is doing, and how
  // many ticks the current travel / door phase has lasted.
  int         m_floor;
  bit         m_up, m_move, m_door;
  logic [N-1:0] m_req;
  int         m_elapsed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pending(input logic [N-1:0] req, input int from, input bit up);
    pending = 1'b0;
    for (int i = 0; i < N; i++)
      if (req[i] && (up ? (i > from) : (i < from))) pending = 1'b1;
  endfunction

  task automatic model_step(input bit r, input logic [N-1:0] b);
    logic [N-1:0] old_req;
    bit d;
    if (r) begin
      m_floor = 0; m_up = 1; m_move = 0; m_door = 0; m_elapsed = 0; m_req = '0;
      return;
    end
    old_req = m_req;
    if (m_move) begin
      m_req = m_req | b;
      m_elapsed++;
      if (m_elapsed == TRAVEL) begin
        m_elapsed = 0;
        m_floor = m_up ? m_floor + 1 : m_floor - 1;
        if (m_req[m_floor]) begin
          m_req[m_floor] = 1'b0;
          m_move = 0;
          m_door = 1;
        end else if (!pending(m_req, m_floor, m_up)) begin
          m_move = 0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (b[i] && i != m_floor) m_req[i] = 1'b1;
      if (m_door) begin
        if (b[m_floor]) m_elapsed = 0;
        else begin
          m_elapsed++;
          if (m_elapsed == DOORT) begin
            m_door = 0;
            m_elapsed = 0;
          end
        end
      end else if (b[m_floor]) begin
        m_door = 1;
        m_elapsed = 0;
      end else begin
        d = (m_floor == N - 1) ? 1'b0 : ((m_floor == 0) ? 1'b1 : m_up);
        if (pending(old_req, m_floor, d)) begin
          m_up = d; m_move = 1; m_elapsed = 0;
        end else if (pending(old_req, m_floor, !d)) begin
          m_up = !d; m_move = 1; m_elapsed = 0;
        end
      end
    end
  endtask

  function automatic logic [10:0] snap();
    logic [N-1:0] fl;
    fl = '0;
    fl[m_floor] = 1'b1;
    snap = {m_req, fl, m_door, m_move, m_up};
  endfunction

  task automatic cycle(input bit r, input logic [N-1:0] b);
    rst1 = r;
    bus1.button = b;
    @(posedge clk);
    model_step(r, b);
    sb_q.push_back(snap());
    #1;
  endtask

  initial begin
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        check("scoreboard {led,floor,door,moving,dir_up}",
              {21'd0, bus1.led, bus1.floor, bus1.door, bus1.moving, bus1.dir_up}, {21'd0, exp});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int c, t1, t2;
    logic [N-1:0] prev, b;
    rst1 = 1'b1; rst2 = 1'b1;
    bus1.button = '0; bus2.button = '0;

    cycle(1, '0);
    cycle(1, '0);
    check("reset_floor", bus1.floor, 4'b0001);
    check("reset_led", bus1.led, 4'b0000);

    // Trip from floor 0 to floor 3
    cycle(0, 4'b1000);
    check("led_latched", bus1.led, 4'b1000);
    n = 0;
    do begin cycle(0, '0); n++; end while (!(bus1.floor == 4'b1000 && bus1.door) && n < 30);
    check("arrive_floor3_cycles", n, 7);
    check("led_clear_on_arrival", bus1.led, 4'b0000);
    n = 0;
    do begin cycle(0, '0); n++; end while (bus1.door && n < 30);
    check("door_open_ticks", n, 3);

    // Two requests below the top floor
    cycle(0, 4'b0101);
    cycle(0, '0);
    check("dir_flip_down", bus1.dir_up, 1'b0);
    n = 0;
    do begin cycle(0, '0); n++; end while (!bus1.door && n < 30);
    check("first_stop_floor2", bus1.floor, 4'b0100);
    check("led_after_floor2", bus1.led, 4'b0001);
    repeat (25) cycle(0, '0);
    check("parked_floor0", bus1.floor, 4'b0001);
    check("all_served", bus1.led, 4'b0000);

    // Door hold at floor 1
    cycle(0, 4'b0010);
    n = 0;
    do begin cycle(0, '0); n++; end while (!bus1.door && n < 30);
    check("door_at_floor1", bus1.floor, 4'b0010);
    repeat (5) cycle(0, 4'b0010);
    check("door_held", bus1.door, 1'b1);
    n = 0;
    do begin cycle(0, '0); n++; end while (bus1.door && n < 30);
    check("door_after_release", n, 3);

    // Request picked up mid-sweep
    cycle(0, 4'b0001);
    repeat (15) cycle(0, '0);
    cycle(0, 4'b1000);
    n = 0;
    do begin cycle(0, '0); n++; end while (!(bus1.floor == 4'b0010 && bus1.moving) && n < 30);
    cycle(0, 4'b0100);
    n = 0;
    do begin cycle(0, '0); n++; end while (!bus1.door && n < 30);
    check("sweep_stop_floor2", bus1.floor, 4'b0100);
    check("sweep_led_pending", bus1.led, 4'b1000);
    n = 0;
    do begin cycle(0, '0); n++; end while (!(bus1.floor == 4'b1000 && bus1.door) && n < 30);
    check("sweep_then_floor3", bus1.floor, 4'b1000);
    repeat (5) cycle(0, '0);

    // Reset mid-travel
    cycle(0, 4'b0001);
    n = 0;
    do begin cycle(0, '0); n++; end while (!(bus1.floor == 4'b0100 && bus1.moving) && n < 30);
    cycle(0, 4'b1000);
    cycle(1, '0);
    check("midtravel_rst_floor", bus1.floor, 4'b0001);
    check("midtravel_rst_led", bus1.led, 4'b0000);
    check("midtravel_rst_moving", bus1.moving, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      b = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      cycle(($urandom_range(0, 299) == 0), b);
    end

    // Prescaled instance: floor-to-floor interval in clk cycles
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    check("tick4_reset_floor", bus2.floor, 4'b0001);
    bus2.button = 4'b1000;
    @(posedge clk);
    #1 bus2.button = '0;
    c = 0; t1 = -1; t2 = -1;
    prev = bus2.floor;
    while (c < 200 && t2 < 0) begin
      @(posedge clk);
      #1;
      c++;
      if (bus2.floor != prev) begin
        if (t1 < 0) t1 = c; else t2 = c;
        prev = bus2.floor;
      end
    end
    check("tick4_travel_clk", t2 - t1, 8);
    check("tick4_second_floor", bus2.floor, 4'b0100);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
